coherence_bus_controller: RTL and testbench
===========================================

Name: coherence_bus_controller

Overview:
- Memory/coherence controller between two private L1 cache pairs (one I$ and one D$ per core) and a single shared RAM port.
- Arbitrates instruction fetches, data block fills and writebacks, and runs MSI snooping: invalidates on write-intent misses and forwards dirty blocks cache-to-cache.
- One RAM transaction in flight; data blocks are 2 words, instruction fetches are 1 word.

Parameters:
CPUS, 2, number of cores; only 2 supported
WORD_W, 32, word width (word_t)
BLK_WORDS, 2, words per data block

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
iREN  in  2  per-core instruction read request
iaddr  in  2x32  per-core instruction address
dREN  in  2  per-core data read (block fill) request
dWEN  in  2  per-core data write (writeback, or snoop flush when snooped)
daddr  in  2x32  per-core data word address; cache steps the word offset itself
dstore  in  2x32  per-core write data
ccwrite  in  2  requester: fill is write-intent (I->M); snooped cache: holds block in M
cctrans  in  2  cache is in a coherence transition; gates snoop on dREN
iwait  out  2  high = I$ access not complete
dwait  out  2  high = D$ access not complete
iload  out  2x32  instruction data
dload  out  2x32  data fill word
ccwait  out  2  freeze core, service snoop
ccinv  out  2  invalidate ccsnoopaddr block
ccsnoopaddr  out  2x32  snooped block address
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset: state IDLE, grant pointer = 0, word counter = 0; all iwait/dwait = 1; ccwait, ccinv, ramREN, ramWEN = 0; all address/data outputs = 0.
- Outputs are combinational from the registered state, grant, and counter. Only state, req (1 bit), last_grant, and wcnt are registered.
- IDLE arbitration:
  - Data requests beat instruction requests.
  - Between cores, round-robin: the core not in last_grant wins a tie.
  - The winner is latched as req; the other core is snp.
  - dWEN[req] -> WB.
  - dREN[req] with cctrans[req] -> SNOOP.
  - dREN[req] without cctrans -> LOAD.
  - iREN only -> IFETCH.
  - last_grant updates on entry to any non-IDLE state.
- SNOOP (exactly 1 cycle): ccwait[snp] = 1, ccsnoopaddr[snp] = daddr[req] with offset cleared, ccinv[snp] = ccwrite[req]. Next state: ccwrite[snp] = 1 -> FWD, else LOAD.
- LOAD: ramREN = 1, ramaddr = daddr[req], dload[req] = ramload.
  - dwait[req] = 0 only in cycles where ramstate == ACCESS; wcnt increments on those cycles.
  - After BLK_WORDS ACCESS cycles -> IDLE.
- FWD: ccwait[snp] and ccinv[snp] held as in SNOOP. The snooped cache drives dWEN/daddr/dstore.
  - ramWEN = 1, ramaddr = daddr[snp], ramstore = dstore[snp], dload[req] = dstore[snp].
  - On ACCESS: dwait[req] = dwait[snp] = 0 and wcnt increments.
  - After BLK_WORDS -> IDLE. Memory is updated and the requester is filled in the same beats.
- WB: ramWEN = 1, ramaddr = daddr[req], ramstore = dstore[req]. dwait[req] = 0 on ACCESS; after BLK_WORDS -> IDLE.
- IFETCH: ramREN = 1, ramaddr = iaddr[req], iload[req] = ramload. iwait[req] = 0 on ACCESS, then -> IDLE.
- BUSY, FREE, and ERROR are treated as not ready: hold state and outputs, and never advance wcnt. ERROR is not reported.
- A request dropped mid-transaction (cache misbehaviour) does not abort the FSM; the state completes its count.
- wcnt resets to 0 on every IDLE entry.
- The non-granted core sees its wait bits held at 1 throughout.
- Asserting RST mid-transaction returns all outputs to reset values immediately, with no completion.
- ramREN and ramWEN are never both 1.

Test Plan:
1. IFETCH: core0 iREN, iaddr=0x100; RAM BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> iload[0]=0xDEADBEEF and iwait[0]=0 for exactly 1 cycle, then IDLE; iwait[1] stays 1.
2. Tie and round-robin: both cores assert dREN with cctrans=0 on the same cycle after reset -> core1 is granted first (last_grant=0). The next tie grants core0. The instruction request from core0 waits until the data fill completes.
3. Invalidate: core0 dREN, cctrans=1, ccwrite=1, daddr=0x200; core1 ccwrite=0 -> for 1 cycle ccwait[1]=1, ccinv[1]=1, ccsnoopaddr[1]=0x200; then 2 RAM reads at 0x200/0x204, each pulsing dwait[0]=0.
4. Dirty forward: core1 requests 0x300 with cctrans=1; core0 ccwrite=1 and drives dstore 0xAAAA0000/0xAAAA0004 -> ramWEN=1 twice. dload[1] equals each dstore, and dwait[0] and dwait[1] both pulse low each beat.
5. Writeback: core0 dWEN, daddr=0x400/0x404, RAM returns ERROR 1 cycle then ACCESS -> no advance during ERROR; 2 writes complete; ramREN stays 0.
6. Reset mid-LOAD after 1 beat -> ramREN=0 and all wait bits=1 asynchronously; next request starts with wcnt=0.

Source files
------------

// File: rtl/coherence_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : coherence_bus_controller
// Brief    : Two-core MSI snooping bus controller arbitrating I$/D$ traffic
//            onto a single shared RAM port, one transaction in flight.
// Revision : 1.0
// ============================================================================
module coherence_bus_controller #(
    parameter int CPUS      = 2,
    parameter int WORD_W    = 32,
    parameter int BLK_WORDS = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [CPUS-1:0]                iREN,
    input  logic [CPUS-1:0][WORD_W-1:0]    iaddr,
    input  logic [CPUS-1:0]                dREN,
    input  logic [CPUS-1:0]                dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]    daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]    dstore,
    input  logic [CPUS-1:0]                ccwrite,
    input  logic [CPUS-1:0]                cctrans,
    output logic [CPUS-1:0]                iwait,
    output logic [CPUS-1:0]                dwait,
    output logic [CPUS-1:0][WORD_W-1:0]    iload,
    output logic [CPUS-1:0][WORD_W-1:0]    dload,
    output logic [CPUS-1:0]                ccwait,
    output logic [CPUS-1:0]                ccinv,
    output logic [CPUS-1:0][WORD_W-1:0]    ccsnoopaddr,
    output logic                           ramREN,
    output logic                           ramWEN,
    output logic [WORD_W-1:0]              ramaddr,
    output logic [WORD_W-1:0]              ramstore,
    input  logic [WORD_W-1:0]              ramload,
    input  logic [1:0]                     ramstate
);

    localparam int              c_cnt_w      = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam int              c_blk_bytes  = BLK_WORDS * (WORD_W / 8);
    localparam logic [WORD_W-1:0] c_blk_mask = ~(WORD_W'(c_blk_bytes - 1));
    localparam logic [1:0]      c_ram_access = 2'd2;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BLK_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNOOP  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_FWD    = 3'd3,
        ST_WB     = 3'd4,
        ST_IFETCH = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_req;
    logic                 r_last_grant;
    logic [c_cnt_w-1:0]   r_wcnt;

    logic                 w_snp;
    logic                 w_winner;
    logic [CPUS-1:0]      w_dreq;
    logic                 w_access;
    logic                 w_last;
    logic                 w_incr;

    assign w_snp    = ~r_req;
    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == c_ram_access);
    assign w_last   = (r_wcnt == c_last_beat);

    // Data beats instruction; on a tie the core that did not win last time goes.
    always_comb begin
        w_winner = 1'b0;
        if (|w_dreq) begin
            w_winner = (&w_dreq) ? ~r_last_grant : w_dreq[1];
        end else begin
            w_winner = (&iREN) ? ~r_last_grant : iREN[1];
        end
    end

    always_comb begin
        w_next      = r_state;
        w_incr      = 1'b0;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (r_state)
            ST_IDLE: begin
                if (dWEN[w_winner]) begin
                    w_next = ST_WB;
                end else if (dREN[w_winner]) begin
                    w_next = cctrans[w_winner] ? ST_SNOOP : ST_LOAD;
                end else if (iREN[w_winner]) begin
                    w_next = ST_IFETCH;
                end
            end

            ST_SNOOP: begin
                ccwait[w_snp]      = 1'b1;
                ccinv[w_snp]       = ccwrite[r_req];
                ccsnoopaddr[w_snp] = daddr[r_req] & c_blk_mask;
                w_next             = ccwrite[w_snp] ? ST_FWD : ST_LOAD;
            end

            ST_LOAD: begin
                ramREN       = 1'b1;
                ramaddr      = daddr[r_req];
                dload[r_req] = ramload;
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    w_incr       = 1'b1;
                    if (w_last) w_next = ST_IDLE;
                end
            end

            // Snooped M-holder flushes; RAM and requester take the same beats.
            ST_FWD: begin
                ccwait[w_snp]      = 1'b1;
                ccinv[w_snp]       = ccwrite[r_req];
                ccsnoopaddr[w_snp] = daddr[r_req] & c_blk_mask;
                ramWEN             = 1'b1;
                ramaddr            = daddr[w_snp];
                ramstore           = dstore[w_snp];
                dload[r_req]       = dstore[w_snp];
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    dwait[w_snp] = 1'b0;
                    w_incr       = 1'b1;
                    if (w_last) w_next = ST_IDLE;
                end
            end

            ST_WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_req];
                ramstore = dstore[r_req];
                if (w_access) begin
                    dwait[r_req] = 1'b0;
                    w_incr       = 1'b1;
                    if (w_last) w_next = ST_IDLE;
                end
            end

            ST_IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[r_req];
                iload[r_req] = ramload;
                if (w_access) begin
                    iwait[r_req] = 1'b0;
                    w_next       = ST_IDLE;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_last_grant <= 1'b0;
            r_wcnt       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_next != ST_IDLE) begin
                r_req        <= w_winner;
                r_last_grant <= w_winner;
            end
            if (w_next == ST_IDLE) begin
                r_wcnt <= '0;
            end else if (w_incr) begin
                r_wcnt <= r_wcnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_coherence_bus_controller
// Brief    : Directed self-checking bench for coherence_bus_controller.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_coherence_bus_controller;

    localparam logic [1:0] c_free   = 2'd0;
    localparam logic [1:0] c_busy   = 2'd1;
    localparam logic [1:0] c_access = 2'd2;
    localparam logic [1:0] c_error  = 2'd3;

    logic              CLK = 1'b0;
    logic              RST;
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        ccwrite;
    logic [1:0]        cctrans;
    logic [1:0]        iwait;
    logic [1:0]        dwait;
    logic [1:0][31:0]  iload;
    logic [1:0][31:0]  dload;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;

    int n_checks = 0;
    int n_errors = 0;

    coherence_bus_controller #(.CPUS(2), .WORD_W(32), .BLK_WORDS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge; inputs are then changed and sampled #1 later.
    task automatic cyc;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0;
        dstore = '0; ccwrite = '0; cctrans = '0; ramload = '0; ramstate = c_free;
        cyc; #1;
        check("rst_iwait",  32'(iwait), 32'h3);
        check("rst_dwait",  32'(dwait), 32'h3);
        check("rst_ren",    32'(ramREN), 32'h0);
        check("rst_wen",    32'(ramWEN), 32'h0);
        check("rst_addr",   ramaddr, 32'h0);
        check("rst_ccwait", 32'(ccwait), 32'h0);
        check("rst_ccinv",  32'(ccinv), 32'h0);
        RST = 1'b0;

        // 1. instruction fetch with two BUSY cycles
        cyc; iREN = 2'b01; iaddr[0] = 32'h100; ramstate = c_busy; #1;
        check("if_idle_ren", 32'(ramREN), 32'h0);
        cyc; #1;
        check("if_ren",   32'(ramREN), 32'h1);
        check("if_addr",  ramaddr, 32'h100);
        check("if_busy1", 32'(iwait), 32'h3);
        cyc; #1;
        check("if_busy2", 32'(iwait), 32'h3);
        cyc; ramstate = c_access; ramload = 32'hDEADBEEF; #1;
        check("if_iload", iload[0], 32'hDEADBEEF);
        check("if_iwait", 32'(iwait), 32'h2);
        cyc; iREN = 2'b00; ramstate = c_free; #1;
        check("if_done_iwait", 32'(iwait), 32'h3);
        check("if_done_ren",   32'(ramREN), 32'h0);

        // 2. data tie -> core1 first, next tie -> core0, then the pending ifetch
        cyc; dREN = 2'b11; iREN = 2'b01; iaddr[0] = 32'h104;
        daddr[0] = 32'h500; daddr[1] = 32'h600; #1;
        cyc; ramstate = c_access; ramload = 32'h11; #1;
        check("rr1_addr",  ramaddr, 32'h600);
        check("rr1_dwait", 32'(dwait), 32'h1);
        check("rr1_dload", dload[1], 32'h11);
        check("rr1_iwait", 32'(iwait), 32'h3);
        cyc; daddr[1] = 32'h604; ramload = 32'h22; #1;
        check("rr1_addr2", ramaddr, 32'h604);
        check("rr1_dwait2", 32'(dwait), 32'h1);
        cyc; daddr[1] = 32'h700; ramstate = c_free; #1;
        check("rr_idle_dwait", 32'(dwait), 32'h3);
        check("rr_idle_ren",   32'(ramREN), 32'h0);
        cyc; ramstate = c_access; ramload = 32'h33; #1;
        check("rr2_addr",  ramaddr, 32'h500);
        check("rr2_dwait", 32'(dwait), 32'h2);
        check("rr2_iwait", 32'(iwait), 32'h3);
        cyc; daddr[0] = 32'h504; #1;
        check("rr2_addr2", ramaddr, 32'h504);
        cyc; dREN = 2'b00; ramstate = c_free; #1;
        check("rr_idle2_ren", 32'(ramREN), 32'h0);
        cyc; ramstate = c_access; ramload = 32'hCAFE; #1;
        check("rr_if_addr",  ramaddr, 32'h104);
        check("rr_if_iwait", 32'(iwait), 32'h2);
        check("rr_if_iload", iload[0], 32'hCAFE);
        cyc; iREN = 2'b00; ramstate = c_free; #1;

        // 3. write-intent miss invalidates the other core
        cyc; dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h200; #1;
        cyc; #1;
        check("inv_ccwait", 32'(ccwait), 32'h2);
        check("inv_ccinv",  32'(ccinv), 32'h2);
        check("inv_saddr",  ccsnoopaddr[1], 32'h200);
        check("inv_ren",    32'(ramREN), 32'h0);
        cyc; ramstate = c_access; ramload = 32'h44; #1;
        check("inv_ld_addr",   ramaddr, 32'h200);
        check("inv_ld_dwait",  32'(dwait), 32'h2);
        check("inv_ld_ccwait", 32'(ccwait), 32'h0);
        cyc; daddr[0] = 32'h204; #1;
        check("inv_ld_addr2",  ramaddr, 32'h204);
        check("inv_ld_dwait2", 32'(dwait), 32'h2);
        cyc; dREN = '0; cctrans = '0; ccwrite = '0; ramstate = c_free; #1;

        // 4. dirty block forwarded from core0 to core1
        cyc; dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b01; daddr[1] = 32'h300; #1;
        cyc; #1;
        check("fwd_sn_ccwait", 32'(ccwait), 32'h1);
        check("fwd_sn_ccinv",  32'(ccinv), 32'h0);
        check("fwd_sn_saddr",  ccsnoopaddr[0], 32'h300);
        cyc; dWEN = 2'b01; daddr[0] = 32'h300; dstore[0] = 32'hAAAA0000; ramstate = c_access; #1;
        check("fwd_wen1",   32'(ramWEN), 32'h1);
        check("fwd_ren1",   32'(ramREN), 32'h0);
        check("fwd_addr1",  ramaddr, 32'h300);
        check("fwd_store1", ramstore, 32'hAAAA0000);
        check("fwd_dload1", dload[1], 32'hAAAA0000);
        check("fwd_dwait1", 32'(dwait), 32'h0);
        check("fwd_ccwait", 32'(ccwait), 32'h1);
        cyc; daddr[0] = 32'h304; dstore[0] = 32'hAAAA0004; #1;
        check("fwd_addr2",  ramaddr, 32'h304);
        check("fwd_dload2", dload[1], 32'hAAAA0004);
        check("fwd_dwait2", 32'(dwait), 32'h0);
        cyc; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramstate = c_free; #1;
        check("fwd_done_wen", 32'(ramWEN), 32'h0);

        // 5. writeback with an ERROR cycle that must not advance
        cyc; dWEN = 2'b01; daddr[0] = 32'h400; dstore[0] = 32'h44; #1;
        cyc; ramstate = c_error; #1;
        check("wb_err_wen",   32'(ramWEN), 32'h1);
        check("wb_err_dwait", 32'(dwait), 32'h3);
        cyc; ramstate = c_access; #1;
        check("wb_addr1",  ramaddr, 32'h400);
        check("wb_store1", ramstore, 32'h44);
        check("wb_dwait1", 32'(dwait), 32'h2);
        cyc; daddr[0] = 32'h404; dstore[0] = 32'h55; #1;
        check("wb_wen2",   32'(ramWEN), 32'h1);
        check("wb_addr2",  ramaddr, 32'h404);
        check("wb_ren",    32'(ramREN), 32'h0);
        cyc; dWEN = '0; ramstate = c_free; #1;
        check("wb_done_wen", 32'(ramWEN), 32'h0);

        // 6. asynchronous reset after one LOAD beat, then a fresh full fill
        cyc; dREN = 2'b01; daddr[0] = 32'h800; #1;
        cyc; ramstate = c_access; #1;
        check("rl_dwait1", 32'(dwait), 32'h2);
        cyc; ramstate = c_busy; daddr[0] = 32'h804; #1;
        check("rl_ren_pre", 32'(ramREN), 32'h1);
        #1 RST = 1'b1; #1;
        check("rl_rst_ren",   32'(ramREN), 32'h0);
        check("rl_rst_dwait", 32'(dwait), 32'h3);
        check("rl_rst_iwait", 32'(iwait), 32'h3);
        cyc; RST = 1'b0; daddr[0] = 32'h800; ramstate = c_free; #1;
        cyc; ramstate = c_access; #1;
        check("rl2_addr1",  ramaddr, 32'h800);
        check("rl2_dwait1", 32'(dwait), 32'h2);
        cyc; daddr[0] = 32'h804; #1;
        check("rl2_ren2",   32'(ramREN), 32'h1);
        check("rl2_dwait2", 32'(dwait), 32'h2);
        cyc; dREN = '0; ramstate = c_free; #1;
        check("rl2_done_ren", 32'(ramREN), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
